// File: rtl/qam16_tx_mod.sv
// qam16_tx_mod -- QAM-16 transmit modulator.
//
// Accepts one 4-bit symbol per start strobe, Gray-maps each 2-bit field to
// an I/Q level (+-A, +-3A), then rotates the point by the current NCO phase
// with a 2^COUNT_WIDTH-iteration rotation-mode CORDIC. The phase accumulator
// advances by freq_word once per accepted symbol. CORDIC gain (~1.6468) is
// left uncompensated on purpose; the receiver AGC absorbs it.
//
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : symbol strobe, accepted only while busy=0
//   symbol[3:0] : [3:2] selects I level, [1:0] selects Q level
//   freq_word   : phase increment per accepted symbol, sampled at accept
//   phase_clr   : clears the phase accumulator, honoured only when idle
//   x_out/y_out : rotated sample, registered, held between ready pulses
//   ready       : one-cycle pulse, x_out/y_out updated
//   busy        : high from the cycle after accept through the ready cycle
module qam16_tx_mod #(
   parameter int width_data  = 16,
   parameter int width_reg   = 18,
   parameter int COUNT_WIDTH = 4,
   parameter int AMP         = 2048
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [3:0]            symbol,
   input  logic [width_data-1:0] freq_word,
   input  logic                  phase_clr,
   output logic [width_data-1:0] x_out,
   output logic [width_data-1:0] y_out,
   output logic                  ready,
   output logic                  busy
);

   localparam int GUARD = width_reg - width_data;
   localparam int N     = 1 << COUNT_WIDTH;

   // Quarter and half turn in accumulator units.
   localparam logic [width_data-1:0] QTR  = width_data'(1) << (width_data - 2);
   localparam logic [width_data-1:0] HALF = width_data'(1) << (width_data - 1);

   // Levels carried with GUARD extra LSBs so the per-iteration shifts lose
   // less precision; they are dropped again when the result is registered.
   localparam logic signed [width_reg-1:0] LVL1 = width_reg'(AMP) <<< GUARD;
   localparam logic signed [width_reg-1:0] LVL3 = width_reg'(3 * AMP) <<< GUARD;

   typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

   typedef struct packed {
      logic [3:0]            symbol;
      logic [width_data-1:0] freq_word;
   } sym_req_t;

   state_t                      state, state_nx;
   sym_req_t                    req_q;
   logic [COUNT_WIDTH-1:0]      cnt;
   logic [width_data-1:0]       acc;
   logic signed [width_reg-1:0] x_r, y_r, z_r;
   logic signed [width_reg-1:0] x_nx, y_nx, z_nx, x_sh, y_sh, at;
   logic signed [width_reg-1:0] x_ld, y_ld, z_ld, i_lv, q_lv;
   logic [width_data-1:0]       res;
   logic                        last;

   function automatic logic signed [width_reg-1:0] gray_lvl(input logic [1:0] b);
      case (b)
         2'b00:   gray_lvl = -LVL3;
         2'b01:   gray_lvl = -LVL1;
         2'b11:   gray_lvl = LVL1;
         default: gray_lvl = LVL3;
      endcase
   endfunction

   // atan(2^-i) in units of 2^-16 turn.
   function automatic int atan_lut(input int i);
      case (i)
         0:       atan_lut = 8192;
         1:       atan_lut = 4836;
         2:       atan_lut = 2555;
         3:       atan_lut = 1297;
         4:       atan_lut = 651;
         5:       atan_lut = 326;
         6:       atan_lut = 163;
         7:       atan_lut = 81;
         8:       atan_lut = 41;
         9:       atan_lut = 20;
         10:      atan_lut = 10;
         11:      atan_lut = 5;
         12:      atan_lut = 3;
         13:      atan_lut = 1;
         14:      atan_lut = 1;
         default: atan_lut = 0;
      endcase
   endfunction

   assign last = (cnt == COUNT_WIDTH'(N - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    state_nx = ITER;
         ITER:    if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ready = (state == DONE);
      busy  = (state != IDLE);
   end

   // Quadrant pre-rotation: fold the phase into [0, quarter turn) by an
   // exact multiple of 90 degrees so the CORDIC only handles the residual.
   always_comb begin
      i_lv = gray_lvl(req_q.symbol[3:2]);
      q_lv = gray_lvl(req_q.symbol[1:0]);
      x_ld = i_lv;
      y_ld = q_lv;
      res  = acc;
      case (acc[width_data-1 -: 2])
         2'b01: begin x_ld = -q_lv; y_ld = i_lv;  res = acc - QTR;  end
         2'b10: begin x_ld = -i_lv; y_ld = -q_lv; res = acc - HALF; end
         2'b11: begin x_ld = q_lv;  y_ld = -i_lv; res = acc + QTR;  end
         default: ;
      endcase
      z_ld = {{GUARD{res[width_data-1]}}, res};
   end

   // One CORDIC micro-rotation; direction follows the sign of the residual.
   always_comb begin
      x_sh = x_r >>> cnt;
      y_sh = y_r >>> cnt;
      at   = width_reg'(atan_lut(int'(cnt)));
      if (!z_r[width_reg-1]) begin
         x_nx = x_r - y_sh;
         y_nx = y_r + x_sh;
         z_nx = z_r - at;
      end else begin
         x_nx = x_r + y_sh;
         y_nx = y_r - x_sh;
         z_nx = z_r + at;
      end
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q <= '0;
         acc   <= '0;
         cnt   <= '0;
         x_r   <= '0;
         y_r   <= '0;
         z_r   <= '0;
         x_out <= '0;
         y_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Clear lands before the accept, so a simultaneous start sees phase 0.
               if (phase_clr) acc <= '0;
               if (start) begin
                  req_q.symbol    <= symbol;
                  req_q.freq_word <= freq_word;
               end
            end
            LOAD: begin
               acc <= acc + req_q.freq_word;
               cnt <= '0;
               x_r <= x_ld;
               y_r <= y_ld;
               z_r <= z_ld;
            end
            ITER: begin
               x_r <= x_nx;
               y_r <= y_nx;
               z_r <= z_nx;
               cnt <= cnt + COUNT_WIDTH'(1);
               // Capture the final rotation directly so the sample is valid in DONE.
               if (last) begin
                  x_out <= x_nx[GUARD +: width_data];
                  y_out <= y_nx[GUARD +: width_data];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_qam16_tx_mod.sv
module tb_qam16_tx_mod;
   localparam int WD  = 16;
   localparam int AMP = 2048;
   localparam int LAT = 18;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          phase_clr = 1'b0;
   logic [3:0]    symbol = '0;
   logic [WD-1:0] freq_word = '0;
   logic [WD-1:0] x_out, y_out;
   logic          ready, busy;

   qam16_tx_mod #(.width_data(WD), .width_reg(WD + 2), .COUNT_WIDTH(4), .AMP(AMP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .symbol(symbol), .freq_word(freq_word),
      .phase_clr(phase_clr), .x_out(x_out), .y_out(y_out), .ready(ready), .busy(busy));

   always #5 clk = ~clk;

   typedef struct {
      int  due;
      real ex;
      real ey;
      int  tol;
   } exp_t;

   exp_t          sb[$];
   int            cyc = 0;
   int            n_checks = 0;
   int            n_errors = 0;
   int            last_acc = -1000;
   bit            chk_en = 1'b0;
   logic [WD-1:0] model_acc = '0;
   real           kgain = 1.0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string nm, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic chk_val(input string nm, input int got, input real exp, input int tol);
      real d;
      n_checks++;
      d = real'(got) - exp;
      if (d < 0.0) d = -d;
      if (d > real'(tol)) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0.2f +-%0d (cycle %0d)", nm, got, exp, tol, cyc);
      end
   endtask

   function automatic real lvl(input logic [1:0] b);
      case (b)
         2'b00:   lvl = -3.0 * AMP;
         2'b01:   lvl = -1.0 * AMP;
         2'b11:   lvl = 1.0 * AMP;
         default: lvl = 3.0 * AMP;
      endcase
   endfunction

   // Ideal rotation of the constellation point by p (fraction of a turn), scaled by the CORDIC gain.
   task automatic push_exp(input logic [3:0] sy, input logic [WD-1:0] p, input int v);
      exp_t e;
      real  th, iv, qv;
      th   = 2.0 * 3.14159265358979 * real'(p) / 65536.0;
      iv   = lvl(sy[3:2]);
      qv   = lvl(sy[1:0]);
      e.ex = kgain * (iv * $cos(th) - qv * $sin(th));
      e.ey = kgain * (iv * $sin(th) + qv * $cos(th));
      e.due = v + LAT;
      e.tol = (p[13:0] == 14'd0) ? 4 : 10;
      sb.push_back(e);
   endtask

   // One cycle of stimulus; the model decides acceptance from its own timing.
   task automatic drive(input bit st, input logic [3:0] sy, input logic [WD-1:0] fw, input bit clr);
      @(negedge clk);
      start = st; symbol = sy; freq_word = fw; phase_clr = clr;
      if (cyc > last_acc + LAT) begin
         if (clr) model_acc = '0;
         if (st) begin
            push_exp(sy, model_acc, cyc);
            last_acc  = cyc;
            model_acc = model_acc + fw;
         end
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while ((sb.size() != 0 || cyc <= last_acc + LAT + 1) && n < 200) begin
         drive(1'b0, 4'd0, 16'd0, 1'b0);
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_done: %0d outstanding after %0d cycles", sb.size(), n);
         sb.delete();
      end
   endtask

   task automatic mid_reset(input string nm);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      chk_en = 1'b0;
      #1;
      chk_eq({nm, "_x"}, int'(x_out), 0);
      chk_eq({nm, "_y"}, int'(y_out), 0);
      chk_eq({nm, "_ready"}, int'(ready), 0);
      chk_eq({nm, "_busy"}, int'(busy), 0);
      sb.delete();
      last_acc = -1000;
      model_acc = '0;
      start = 1'b0;
      phase_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;
   endtask

   // Monitor: busy against model timing every cycle, samples on each ready pulse.
   always @(negedge clk) begin
      if (chk_en) begin
         chk_eq("busy", int'(busy), int'(cyc >= last_acc + 1 && cyc <= last_acc + LAT));
         if (ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_ready: got ready=1 expected none (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk_eq("latency", cyc, e.due);
               chk_val("x_out", int'($signed(x_out)), e.ex, e.tol);
               chk_val("y_out", int'($signed(y_out)), e.ey, e.tol);
            end
         end else if (sb.size() != 0 && sb[0].due < cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL missing_ready: got none expected ready at cycle %0d", sb[0].due);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

      // Power-on reset values
      repeat (3) @(negedge clk);
      chk_eq("rst_x", int'(x_out), 0);
      chk_eq("rst_y", int'(y_out), 0);
      chk_eq("rst_ready", int'(ready), 0);
      chk_eq("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Phase 0, +3A/+3A, after a phase clear
      drive(1'b0, 4'd0, 16'd0, 1'b1);
      drive(1'b1, 4'b1010, 16'd0, 1'b0);
      wait_done();

      // -3A/-3A and -A/+A at phase 0
      drive(1'b1, 4'b0000, 16'd0, 1'b0);
      wait_done();
      drive(1'b1, 4'b0111, 16'd0, 1'b0);
      wait_done();

      // Asynchronous reset mid-clock with non-zero outputs
      mid_reset("areset");

      // Quarter-turn steps, start held high: four accepts, then accumulator wraps to 0
      drive(1'b0, 4'd0, 16'd0, 1'b1);
      repeat (76) drive(1'b1, 4'b1011, 16'h4000, 1'b0);
      wait_done();
      drive(1'b1, 4'b1010, 16'd0, 1'b0);
      wait_done();

      // Starts (and a clear) while busy and in the ready cycle are ignored
      drive(1'b1, 4'b1101, 16'h2000, 1'b0);
      for (int k = 1; k <= 18; k++) drive(k == 5 || k == 18, 4'b0110, 16'h1000, k == 5);
      wait_done();
      drive(1'b1, 4'b1010, 16'd0, 1'b0);
      wait_done();

      // Random symbols, increments, clears and start pressure
      repeat (600) drive($urandom_range(0, 3) != 0, 4'($urandom), 16'($urandom), $urandom_range(0, 9) == 0);
      wait_done();

      // Reset during ITER aborts the symbol and zeroes the phase
      drive(1'b1, 4'b0101, 16'h3000, 1'b0);
      repeat (8) drive(1'b0, 4'd0, 16'd0, 1'b0);
      mid_reset("iter_reset");
      repeat (25) drive(1'b0, 4'd0, 16'd0, 1'b0);
      chk_eq("post_abort_x", int'(x_out), 0);
      chk_eq("post_abort_y", int'(y_out), 0);
      drive(1'b1, 4'b1010, 16'd0, 1'b0);
      wait_done();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
